// File: rtl/ofm_wr_scheduler.sv
// rtl/ofm_wr_scheduler.sv - OFM write-back scheduler: splits an op into page-safe write-master transfers
module ofm_wr_scheduler #(
    parameter int BEAT_BYTES     = 64,
    parameter int MAX_XFER_BYTES = 4096,
    parameter int SIZE_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_start,
    input  logic [63:0]       wmst_offset,
    input  logic [SIZE_W-1:0] ofm_size,
    input  logic              beat_fire,
    input  logic              wmst_done,
    output logic              wmst_req,
    output logic [63:0]       wmst_addr,
    output logic [63:0]       wmst_xfer_size,
    output logic              busy,
    output logic              op_done,
    output logic              beat_err
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [63:0]       cur_addr;
    logic [SIZE_W-1:0] remain;
    logic [SIZE_W-1:0] beat_cnt;
    logic [SIZE_W-1:0] beat_cnt_next;
    logic [12:0]       page_room;
    logic [63:0]       chunk;
    logic [63:0]       remain_ext;
    logic [63:0]       beat_cnt_ext;
    logic [63:0]       exp_beats;

    // Chunk size: bounded by bytes left, the transfer cap and the room left in the current 4 KB page
    always_comb begin
        page_room  = 13'd4096 - {1'b0, cur_addr[11:0]};
        remain_ext = {{(64-SIZE_W){1'b0}}, remain};
        chunk      = remain_ext;
        if (64'(MAX_XFER_BYTES) < chunk) begin
            chunk = 64'(MAX_XFER_BYTES);
        end
        if ({51'd0, page_room} < chunk) begin
            chunk = {51'd0, page_room};
        end
    end

    // Saturating beat count including the current cycle's handshake, and the beats the chunk should carry
    always_comb begin
        beat_cnt_next = beat_cnt;
        if (beat_fire && (beat_cnt != {SIZE_W{1'b1}})) begin
            beat_cnt_next = beat_cnt + 1'b1;
        end
        beat_cnt_ext = {{(64-SIZE_W){1'b0}}, beat_cnt_next};
        exp_beats    = wmst_xfer_size >> BEAT_SHIFT;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_d  = state_q;
        wmst_req = 1'b0;
        busy     = 1'b1;
        op_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (op_start) begin
                    state_d = (ofm_size == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                wmst_req = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wmst_done) begin
                    state_d = (remain == '0) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                op_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Op bookkeeping: address/remaining bytes, registered chunk descriptor, beat accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr       <= '0;
            remain         <= '0;
            wmst_addr      <= '0;
            wmst_xfer_size <= '0;
            beat_cnt       <= '0;
            beat_err       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_start) begin
                        cur_addr <= wmst_offset;
                        remain   <= ofm_size;
                        beat_err <= 1'b0;
                    end
                end
                S_CALC: begin
                    wmst_addr      <= cur_addr;
                    wmst_xfer_size <= chunk;
                    beat_cnt       <= '0;
                end
                S_REQ: begin
                    cur_addr <= cur_addr + wmst_xfer_size;
                    remain   <= remain - wmst_xfer_size[SIZE_W-1:0];
                    beat_cnt <= beat_cnt_next;
                end
                S_WAIT: begin
                    beat_cnt <= beat_cnt_next;
                    if (wmst_done && (beat_cnt_ext != exp_beats)) begin
                        beat_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_wr_scheduler.sv
// tb/tb_ofm_wr_scheduler.sv - table-driven bench for ofm_wr_scheduler
module tb_ofm_wr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_start_a = 1'b0;
    logic        op_start_b = 1'b0;
    logic [63:0] wmst_offset = '0;
    logic [31:0] ofm_size = '0;
    logic        beat_fire = 1'b0;
    logic        wmst_done = 1'b0;
    logic        sel_b = 1'b0;

    logic        req_a, busy_a, op_done_a, beat_err_a;
    logic [63:0] addr_a, xsize_a;
    logic        req_b, busy_b, op_done_b, beat_err_b;
    logic [63:0] addr_b, xsize_b;

    logic        req, busy, op_done, beat_err;
    logic [63:0] addr, xsize;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sel_b;
        logic [63:0] offset;
        logic [31:0] size;
        logic        short_first;
        int          nchunk;
        int          first;
        logic        exp_err;
    } case_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] size;
    } chunk_t;

    case_t  cases[6];
    chunk_t chunks[13];

    ofm_wr_scheduler #(.BEAT_BYTES(64), .MAX_XFER_BYTES(4096), .SIZE_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .op_start(op_start_a), .wmst_offset(wmst_offset),
        .ofm_size(ofm_size), .beat_fire(beat_fire), .wmst_done(wmst_done),
        .wmst_req(req_a), .wmst_addr(addr_a), .wmst_xfer_size(xsize_a),
        .busy(busy_a), .op_done(op_done_a), .beat_err(beat_err_a)
    );

    ofm_wr_scheduler #(.BEAT_BYTES(64), .MAX_XFER_BYTES(1024), .SIZE_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_start(op_start_b), .wmst_offset(wmst_offset),
        .ofm_size(ofm_size), .beat_fire(beat_fire), .wmst_done(wmst_done),
        .wmst_req(req_b), .wmst_addr(addr_b), .wmst_xfer_size(xsize_b),
        .busy(busy_b), .op_done(op_done_b), .beat_err(beat_err_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        req      = sel_b ? req_b      : req_a;
        addr     = sel_b ? addr_b     : addr_a;
        xsize    = sel_b ? xsize_b    : xsize_a;
        busy     = sel_b ? busy_b     : busy_a;
        op_done  = sel_b ? op_done_b  : op_done_a;
        beat_err = sel_b ? beat_err_b : beat_err_a;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input int c);
        case_t  cs;
        chunk_t ch;
        int     w;
        int     nb;
        cs          = cases[c];
        sel_b       = cs.sel_b;
        wmst_offset = cs.offset;
        ofm_size    = cs.size;
        if (cs.sel_b) op_start_b = 1'b1;
        else          op_start_a = 1'b1;
        step();
        op_start_a = 1'b0;
        op_start_b = 1'b0;
        check($sformatf("c%0d_busy_start", c), busy, 1);
        check($sformatf("c%0d_err_cleared", c), beat_err, 0);
        for (int k = 0; k < cs.nchunk; k++) begin
            ch = chunks[cs.first + k];
            w  = 0;
            while (!req && w < 20) begin
                step();
                w++;
            end
            check($sformatf("c%0d_k%0d_req_latency", c, k), w, 1);
            check($sformatf("c%0d_k%0d_addr", c, k), addr, ch.addr);
            check($sformatf("c%0d_k%0d_size", c, k), xsize, ch.size);
            nb = int'(ch.size >> 6);
            if (cs.short_first && k == 0) nb--;
            step();
            check($sformatf("c%0d_k%0d_req_pulse", c, k), req, 0);
            for (int b = 0; b < nb; b++) begin
                beat_fire = 1'b1;
                wmst_done = (b == nb - 1);
                step();
            end
            beat_fire = 1'b0;
            wmst_done = 1'b0;
        end
        check($sformatf("c%0d_op_done", c), op_done, 1);
        check($sformatf("c%0d_beat_err", c), beat_err, cs.exp_err);
        step();
        check($sformatf("c%0d_idle_busy", c), busy, 0);
        check($sformatf("c%0d_op_done_pulse", c), op_done, 0);
        check($sformatf("c%0d_beat_err_hold", c), beat_err, cs.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int ndone;
        int nbusy;

        cases[0] = '{1'b1, 64'h2000, 32'h1000, 1'b0, 4, 0, 1'b0};
        cases[1] = '{1'b0, 64'h1000, 32'h0400, 1'b0, 1, 4, 1'b0};
        cases[2] = '{1'b0, 64'h0FC0, 32'h0100, 1'b0, 2, 5, 1'b0};
        cases[3] = '{1'b0, 64'h0800, 32'h2000, 1'b0, 3, 7, 1'b0};
        cases[4] = '{1'b0, 64'h1000, 32'h0400, 1'b1, 1, 10, 1'b1};
        cases[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FF00, 32'h0200, 1'b0, 2, 11, 1'b0};

        chunks[0]  = '{64'h2000, 64'h400};
        chunks[1]  = '{64'h2400, 64'h400};
        chunks[2]  = '{64'h2800, 64'h400};
        chunks[3]  = '{64'h2C00, 64'h400};
        chunks[4]  = '{64'h1000, 64'h400};
        chunks[5]  = '{64'h0FC0, 64'h040};
        chunks[6]  = '{64'h1000, 64'h0C0};
        chunks[7]  = '{64'h0800, 64'h800};
        chunks[8]  = '{64'h1000, 64'h1000};
        chunks[9]  = '{64'h2000, 64'h800};
        chunks[10] = '{64'h1000, 64'h400};
        chunks[11] = '{64'hFFFF_FFFF_FFFF_FF00, 64'h100};
        chunks[12] = '{64'h0000, 64'h100};

        step();
        step();
        check("rst_busy", busy_a, 0);
        check("rst_req", req_a, 0);
        check("rst_op_done", op_done_a, 0);
        check("rst_beat_err", beat_err_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_size", xsize_a, 0);
        rst_n = 1'b1;
        step();

        for (int c = 0; c < 6; c++) begin
            run_case(c);
            if (cases[c].exp_err) begin
                step();
                step();
                check("sticky_err_idle", beat_err, 1);
            end
        end
        sel_b = 1'b0;

        // Zero-size op: straight to DONE, no transfer
        wmst_offset = 64'h12_3440;
        ofm_size    = 32'h0;
        op_start_a  = 1'b1;
        step();
        op_start_a = 1'b0;
        nreq = 0; ndone = 0; nbusy = 0;
        for (int i = 0; i < 4; i++) begin
            nreq  += int'(req_a);
            ndone += int'(op_done_a);
            nbusy += int'(busy_a);
            step();
        end
        check("zero_nreq", nreq, 0);
        check("zero_ndone", ndone, 1);
        check("zero_nbusy", nbusy, 1);

        // wmst_done / beat_fire while idle are ignored
        beat_fire = 1'b1;
        wmst_done = 1'b1;
        step();
        step();
        beat_fire = 1'b0;
        wmst_done = 1'b0;
        check("idle_done_busy", busy_a, 0);
        check("idle_done_err", beat_err_a, 0);

        // op_start while busy and in DONE cycle is dropped
        wmst_offset = 64'h3000;
        ofm_size    = 32'h40;
        op_start_a  = 1'b1;
        step();
        op_start_a = 1'b0;
        step();
        check("drop_req", req_a, 1);
        check("drop_addr", addr_a, 64'h3000);
        step();
        op_start_a  = 1'b1;
        wmst_offset = 64'h0;
        ofm_size    = 32'h40;
        beat_fire   = 1'b1;
        wmst_done   = 1'b1;
        step();
        beat_fire = 1'b0;
        wmst_done = 1'b0;
        check("drop_op_done", op_done_a, 1);
        step();
        op_start_a = 1'b0;
        check("drop_idle", busy_a, 0);
        step();
        check("drop_stay_idle", busy_a, 0);
        check("drop_no_req", req_a, 0);
        check("drop_err", beat_err_a, 0);

        // Reset mid-op, then a clean op afterwards
        wmst_offset = 64'h1000;
        ofm_size    = 32'h400;
        op_start_a  = 1'b1;
        step();
        op_start_a = 1'b0;
        step();
        step();
        beat_fire = 1'b1;
        step();
        step();
        beat_fire = 1'b0;
        check("rstmid_busy_before", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy_a, 0);
        check("rstmid_req", req_a, 0);
        check("rstmid_addr", addr_a, 0);
        step();
        check("rstmid_op_done", op_done_a, 0);
        rst_n = 1'b1;
        step();
        run_case(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
